// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer. It issues one PC per instruction at
//               a runtime cycles-per-instruction rate and applies relative or
//               absolute branches. It supports stall and halt, and keeps
//               cycle and retired-instruction performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int                ADDR_W      = 10,
    parameter int                DATA_W      = 32,
    parameter int                TICK_W      = 64,
    parameter logic [ADDR_W-1:0] START_ADDR  = 'h80,
    parameter int                INSTR_BYTES = 4,
    parameter int                CPI_W       = 4,
    parameter int                BR_SHIFT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              stall_i,
    input  logic [CPI_W-1:0]  cpi_i,
    input  logic              br_valid_i,
    input  logic              br_mode_i,
    input  logic [DATA_W-1:0] br_target_i,
    input  logic              halt_req_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              issue_o,
    output logic              retire_o,
    output logic              halted_o,
    output logic [TICK_W-1:0] cycle_cnt_o,
    output logic [TICK_W-1:0] instr_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CPI_W-1:0]    phase_q, phase_d;
    logic [CPI_W-1:0]    cpi_q, cpi_d;
    logic [TICK_W-1:0]   cyc_q, cyc_d;
    logic [TICK_W-1:0]   instr_q, instr_d;
    logic                br_pend_q, br_pend_d;
    logic                br_mode_q, br_mode_d;
    logic [ADDR_W-1:0]   br_tgt_q, br_tgt_d;
    logic                halt_pend_q, halt_pend_d;

    // Only the low ADDR_W bits of the sign-extended target can affect the pc,
    // because a shift left and a truncation never pull in higher bits.
    logic [ADDR_W-1:0]   w_tgt_lo;

    if (DATA_W > ADDR_W) begin : g_tgt_trunc
        logic w_unused_tgt_hi;
        assign w_unused_tgt_hi = ^br_target_i[DATA_W-1:ADDR_W];
        assign w_tgt_lo        = br_target_i[ADDR_W-1:0];
    end else if (DATA_W == ADDR_W) begin : g_tgt_exact
        assign w_tgt_lo = br_target_i;
    end else begin : g_tgt_sext
        assign w_tgt_lo = {{(ADDR_W-DATA_W){br_target_i[DATA_W-1]}}, br_target_i};
    end

    logic                w_active;
    logic [CPI_W-1:0]    w_cpi_in_eff;
    logic [CPI_W-1:0]    w_cpi_cur;
    logic                w_issue;
    logic                w_retire;
    logic                w_br_take;
    logic                w_br_mode;
    logic [ADDR_W-1:0]   w_br_tgt;
    logic [ADDR_W-1:0]   w_br_pc;

    // Phase qualification, issue/retire strobes and branch-target resolution.
    // A request on the retire cycle itself takes priority over a pending one.
    always_comb begin
        w_active     = (state_q == S_RUN) && enable_i && !stall_i;
        w_cpi_in_eff = (cpi_i == '0) ? CPI_W'(1) : cpi_i;
        w_cpi_cur    = (phase_q == '0) ? w_cpi_in_eff : cpi_q;
        w_issue      = w_active && (phase_q == '0);
        w_retire     = w_active && (phase_q == (w_cpi_cur - CPI_W'(1)));
        w_br_take    = br_valid_i || br_pend_q;
        w_br_mode    = br_valid_i ? br_mode_i : br_mode_q;
        w_br_tgt     = br_valid_i ? w_tgt_lo : br_tgt_q;
        w_br_pc      = w_br_mode ? w_br_tgt : (pc_q + (w_br_tgt << BR_SHIFT));
    end

    // Next-state logic for the sequencer FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        phase_d     = phase_q;
        cpi_d       = cpi_q;
        cyc_d       = cyc_q;
        instr_d     = instr_q;
        br_pend_d   = br_pend_q;
        br_mode_d   = br_mode_q;
        br_tgt_d    = br_tgt_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (enable_i) begin
                    cyc_d = cyc_q + TICK_W'(1);
                end
                if (w_active) begin
                    if (phase_q == '0) begin
                        cpi_d = w_cpi_in_eff;
                    end
                    if (w_retire) begin
                        pc_d        = w_br_take ? w_br_pc : (pc_q + ADDR_W'(INSTR_BYTES));
                        instr_d     = instr_q + TICK_W'(1);
                        phase_d     = '0;
                        br_pend_d   = 1'b0;
                        halt_pend_d = 1'b0;
                        if (halt_req_i || halt_pend_q) begin
                            state_d = S_HALT;
                        end
                    end else begin
                        phase_d = phase_q + CPI_W'(1);
                        if (br_valid_i) begin
                            br_pend_d = 1'b1;
                            br_mode_d = br_mode_i;
                            br_tgt_d  = w_tgt_lo;
                        end
                        if (halt_req_i) begin
                            halt_pend_d = 1'b1;
                        end
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pc_q        <= START_ADDR;
            phase_q     <= '0;
            cpi_q       <= CPI_W'(1);
            cyc_q       <= '0;
            instr_q     <= '0;
            br_pend_q   <= 1'b0;
            br_mode_q   <= 1'b0;
            br_tgt_q    <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            phase_q     <= phase_d;
            cpi_q       <= cpi_d;
            cyc_q       <= cyc_d;
            instr_q     <= instr_d;
            br_pend_q   <= br_pend_d;
            br_mode_q   <= br_mode_d;
            br_tgt_q    <= br_tgt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign pc_o        = pc_q;
    assign issue_o     = w_issue;
    assign retire_o    = w_retire;
    assign halted_o    = (state_q == S_HALT);
    assign cycle_cnt_o = cyc_q;
    assign instr_cnt_o = instr_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. An instruction-level
//               model is compared against the DUT on every cycle. Literal
//               checks at the end of each directed scenario pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  cpi = 4'd1;
    logic        br_valid = 1'b0;
    logic        br_mode = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        halt_req = 1'b0;
    logic [9:0]  pc;
    logic        issue;
    logic        retire;
    logic        halted;
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pc_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .stall_i     (stall),
        .cpi_i       (cpi),
        .br_valid_i  (br_valid),
        .br_mode_i   (br_mode),
        .br_target_i (br_target),
        .halt_req_i  (halt_req),
        .pc_o        (pc),
        .issue_o     (issue),
        .retire_o    (retire),
        .halted_o    (halted),
        .cycle_cnt_o (cycle_cnt),
        .instr_cnt_o (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Instruction-level model: tracks the current instruction's length and
    // how many active cycles it has consumed, plus a resolved branch
    // address. Checked at every negedge, then advanced with the inputs the
    // DUT will sample at the coming posedge.
    // ------------------------------------------------------------------
    bit          m_valid   = 1'b0;
    bit          m_running = 1'b0;
    bit          m_halted  = 1'b0;
    logic [9:0]  m_pc      = 10'h080;
    int          m_k       = 0;
    int          m_len     = 1;
    logic [63:0] m_cyc     = 64'd0;
    logic [63:0] m_ins     = 64'd0;
    bit          m_br_has  = 1'b0;
    logic [9:0]  m_br_pc   = 10'h000;
    bit          m_hlt     = 1'b0;

    always @(negedge clk) begin : model
        bit         act;
        int         len;
        bit         e_issue;
        bit         e_retire;
        logic [9:0] tgt;
        act      = m_running && enable && !stall;
        len      = (m_k == 0) ? ((cpi == 4'd0) ? 1 : int'(cpi)) : m_len;
        e_issue  = act && (m_k == 0);
        e_retire = act && (m_k == len - 1);
        if (m_valid) begin
            chk("pc",        {54'd0, pc},     {54'd0, m_pc});
            chk("issue",     {63'd0, issue},  {63'd0, e_issue});
            chk("retire",    {63'd0, retire}, {63'd0, e_retire});
            chk("halted",    {63'd0, halted}, {63'd0, m_halted});
            chk("cycle_cnt", cycle_cnt,       m_cyc);
            chk("instr_cnt", instr_cnt,       m_ins);
        end
        if (!rst_n) begin
            m_valid   = 1'b1;
            m_running = 1'b0;
            m_halted  = 1'b0;
            m_pc      = 10'h080;
            m_k       = 0;
            m_len     = 1;
            m_cyc     = 64'd0;
            m_ins     = 64'd0;
            m_br_has  = 1'b0;
            m_hlt     = 1'b0;
        end else if (m_valid) begin
            if (!m_running && !m_halted) begin
                if (enable) m_running = 1'b1;
            end else if (m_running) begin
                if (enable) m_cyc = m_cyc + 64'd1;
                if (act) begin
                    if (m_k == 0) m_len = len;
                    if (br_valid) begin
                        if (br_mode) tgt = br_target[9:0];
                        else         tgt = m_pc + 10'(longint'($signed(br_target)) * 2);
                        m_br_has = 1'b1;
                        m_br_pc  = tgt;
                    end
                    if (halt_req) m_hlt = 1'b1;
                    if (e_retire) begin
                        m_pc     = m_br_has ? m_br_pc : (m_pc + 10'd4);
                        m_ins    = m_ins + 64'd1;
                        m_k      = 0;
                        m_br_has = 1'b0;
                        if (m_hlt) begin
                            m_running = 1'b0;
                            m_halted  = 1'b1;
                            m_hlt     = 1'b0;
                        end
                    end else begin
                        m_k = m_k + 1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst_n    = 1'b0;
        enable   = 1'b0;
        stall    = 1'b0;
        br_valid = 1'b0;
        halt_req = 1'b0;
        tick(1);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(1);
    endtask

    task automatic br(input logic mode, input logic [31:0] tgt);
        br_valid  = 1'b1;
        br_mode   = mode;
        br_target = tgt;
    endtask

    initial begin
        // 1: reset held two cycles, then four instructions at cpi=3
        tick(2);
        chk("rst_pc",     {54'd0, pc},     64'h80);
        chk("rst_cycle",  cycle_cnt,       64'd0);
        chk("rst_instr",  instr_cnt,       64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        rst_n = 1'b1; enable = 1'b1; cpi = 4'd3;
        tick(1);
        tick(12);
        chk("t1_pc",    {54'd0, pc}, 64'h90);
        chk("t1_instr", instr_cnt,   64'd4);
        chk("t1_cycle", cycle_cnt,   64'd12);

        // 2: cpi=0 behaves as one instruction per cycle; enable=0 freezes
        cpi = 4'd0;
        #1;
        chk("t2_issue",  {63'd0, issue},  64'd1);
        chk("t2_retire", {63'd0, retire}, 64'd1);
        tick(4);
        chk("t2_pc",    {54'd0, pc}, 64'hA0);
        chk("t2_instr", instr_cnt,   64'd8);
        chk("t2_cycle", cycle_cnt,   64'd16);
        enable = 1'b0;
        #1;
        chk("t2_noissue", {63'd0, issue}, 64'd0);
        tick(2);
        chk("t2_hold_pc",    {54'd0, pc}, 64'hA0);
        chk("t2_hold_cycle", cycle_cnt,   64'd16);

        // 3: relative, absolute, wrap, retire-cycle branch, last-wins
        restart();
        cpi = 4'd3;
        tick(6);
        chk("t3_pc88", {54'd0, pc}, 64'h88);
        tick(1);
        br(1'b0, 32'hFFFF_FFFC); tick(1); br_valid = 1'b0;
        tick(1);
        chk("t3_rel", {54'd0, pc}, 64'h80);
        br(1'b1, 32'h0000_03FC); tick(1); br_valid = 1'b0;
        tick(2);
        chk("t3_abs", {54'd0, pc}, 64'h3FC);
        tick(3);
        chk("t3_wrap", {54'd0, pc}, 64'h000);
        tick(2);
        br(1'b0, 32'd8); tick(1); br_valid = 1'b0;
        chk("t3_direct", {54'd0, pc}, 64'h010);
        br(1'b1, 32'h100); tick(1);
        br(1'b1, 32'h200); tick(1); br_valid = 1'b0;
        tick(1);
        chk("t3_last", {54'd0, pc},  64'h200);
        chk("t3_instr", instr_cnt,   64'd7);
        chk("t3_cycle", cycle_cnt,   64'd21);

        // 4: two stalled cycles mid-instruction at cpi=2
        restart();
        cpi = 4'd2;
        tick(1);
        stall = 1'b1;
        tick(2);
        chk("t4_stall_pc",    {54'd0, pc}, 64'h80);
        chk("t4_stall_cycle", cycle_cnt,   64'd3);
        chk("t4_stall_instr", instr_cnt,   64'd0);
        stall = 1'b0;
        tick(1);
        chk("t4_pc",    {54'd0, pc}, 64'h84);
        chk("t4_cycle", cycle_cnt,   64'd4);

        // 5: halt requested at phase 0, cpi=4
        cpi = 4'd4;
        halt_req = 1'b1; tick(1); halt_req = 1'b0;
        tick(3);
        chk("t5_pc",     {54'd0, pc},     64'h88);
        chk("t5_halted", {63'd0, halted}, 64'd1);
        chk("t5_instr",  instr_cnt,       64'd2);
        tick(5);
        chk("t5_frz_pc",    {54'd0, pc}, 64'h88);
        chk("t5_frz_cycle", cycle_cnt,   64'd8);
        chk("t5_frz_instr", instr_cnt,   64'd2);

        // 6: reset at phase 2 with a branch pending discards it
        restart();
        cpi = 4'd4;
        br(1'b1, 32'h200); tick(1); br_valid = 1'b0;
        tick(1);
        rst_n = 1'b0;
        tick(1);
        chk("t6_rst_pc",    {54'd0, pc}, 64'h80);
        chk("t6_rst_cycle", cycle_cnt,   64'd0);
        chk("t6_rst_instr", instr_cnt,   64'd0);
        rst_n = 1'b1;
        tick(1);
        tick(4);
        chk("t6_pc",    {54'd0, pc}, 64'h84);
        chk("t6_instr", instr_cnt,   64'd1);

        // 7: branch and halt together on a retire cycle
        cpi = 4'd1;
        br(1'b1, 32'h100); halt_req = 1'b1;
        tick(1);
        br_valid = 1'b0; halt_req = 1'b0;
        chk("t7_pc",     {54'd0, pc},     64'h100);
        chk("t7_halted", {63'd0, halted}, 64'd1);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
